// File: rtl/cpu_pkg.sv
// Shared CPU definitions: predictor modes and 2-bit branch counter encodings.
package cpu_pkg;

  localparam int MODE_STATIC_NT = 0;
  localparam int MODE_BIMODAL   = 1;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/saturating_counter.sv
// 2-bit up/down saturating counter, used as a next-state function.
module saturating_counter
  import cpu_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic up_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_e'(ctr_i + 2'd1);
    end else if (ctr_i != CTR_SNT) begin
      ctr_o = ctr_e'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit bimodal direction counters, mispredict/redirect
// generation for the EX stage, and saturating performance counters.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int PC_WIDTH   = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int MODE       = MODE_BIMODAL,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic [PC_WIDTH-1:0]   lookupPc,
  output logic                  predictTaken,
  output logic [PC_WIDTH-1:0]   predictTarget,
  input  logic                  updateValid,
  input  logic                  updateIsBranch,
  input  logic [PC_WIDTH-1:0]   updatePc,
  input  logic                  updateTaken,
  input  logic [PC_WIDTH-1:0]   updateTarget,
  input  logic                  updatePredictedTaken,
  input  logic [PC_WIDTH-1:0]   updatePredictedTarget,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   correctPc,
  output logic [PERF_WIDTH-1:0] branchCount,
  output logic [PERF_WIDTH-1:0] mispredictCount
);

  localparam int IDX = $clog2(ENTRIES);

  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + PERF_WIDTH'(1);
  endfunction

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0]  target_q [ENTRIES];
  logic [PC_WIDTH-1:0]  target_d [ENTRIES];
  ctr_e                 ctr_q    [ENTRIES];
  ctr_e                 ctr_d    [ENTRIES];
  logic [PERF_WIDTH-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  logic [IDX-1:0]       l_idx, u_idx;
  logic [TAG_WIDTH-1:0] l_tag, u_tag;
  logic                 l_hit, u_hit, update_en;
  ctr_e                 ctr_upd;

  assign l_idx = lookupPc[IDX+1:2];
  assign l_tag = lookupPc[IDX+1+TAG_WIDTH:IDX+2];
  assign u_idx = updatePc[IDX+1:2];
  assign u_tag = updatePc[IDX+1+TAG_WIDTH:IDX+2];

  // Lookup reads registered state only; a same-cycle update is seen next cycle.
  assign l_hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign predictTaken  = (MODE == MODE_BIMODAL) && l_hit && ctr_q[l_idx][1];
  assign predictTarget = predictTaken ? target_q[l_idx] : lookupPc + PC_WIDTH'(4);

  assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign update_en = updateValid && !freeze;

  saturating_counter u_ctr (
    .ctr_i (ctr_q[u_idx]),
    .up_i  (updateTaken),
    .ctr_o (ctr_upd)
  );

  always_comb begin
    mispredict = 1'b0;
    if (updateValid) begin
      if (updateIsBranch)
        mispredict = (updatePredictedTaken != updateTaken) ||
                     (updateTaken && (updatePredictedTarget != updateTarget));
      else
        mispredict = updatePredictedTaken;
    end
    correctPc = (updateIsBranch && updateTaken) ? updateTarget : updatePc + PC_WIDTH'(4);
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if ((MODE == MODE_BIMODAL) && update_en) begin
      if (updateIsBranch) begin
        if (u_hit) begin
          ctr_d[u_idx] = ctr_upd;
          if (updateTaken) target_d[u_idx] = updateTarget;
        end else if (updateTaken) begin
          valid_d[u_idx]  = 1'b1;
          tag_d[u_idx]    = u_tag;
          target_d[u_idx] = updateTarget;
          ctr_d[u_idx]    = CTR_WT;
        end
      end else if (u_hit) begin
        // A non-branch aliasing a BTB entry must never be predicted again.
        valid_d[u_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update_en) begin
      if (updateIsBranch) branch_cnt_d = sat_inc(branch_cnt_q);
      if (mispredict)     mispred_cnt_d = sat_inc(mispred_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag and target are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign branchCount     = branch_cnt_q;
  assign mispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench: bimodal and static-NT predictors side by side against a behavioural table model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int PC_W    = 32;
  localparam int TAG_W   = 8;
  localparam int PERF_W  = 6;
  localparam int IDX     = 4;
  localparam longint CMAX = (64'd1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst, freeze;
  logic [PC_W-1:0] lookupPc, updatePc, updateTarget, updatePredictedTarget;
  logic updateValid, updateIsBranch, updateTaken, updatePredictedTaken;

  logic pt1, mp1, pt0, mp0;
  logic [PC_W-1:0] ptgt1, cpc1, ptgt0, cpc0;
  logic [PERF_W-1:0] bc1, mc1, bc0, mc0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES), .PC_WIDTH(PC_W), .TAG_WIDTH(TAG_W), .MODE(1), .PERF_WIDTH(PERF_W)) u_bim (
    .clk(clk), .rst(rst), .freeze(freeze), .lookupPc(lookupPc),
    .predictTaken(pt1), .predictTarget(ptgt1),
    .updateValid(updateValid), .updateIsBranch(updateIsBranch), .updatePc(updatePc),
    .updateTaken(updateTaken), .updateTarget(updateTarget),
    .updatePredictedTaken(updatePredictedTaken), .updatePredictedTarget(updatePredictedTarget),
    .mispredict(mp1), .correctPc(cpc1), .branchCount(bc1), .mispredictCount(mc1));

  branch_predictor #(.ENTRIES(ENTRIES), .PC_WIDTH(PC_W), .TAG_WIDTH(TAG_W), .MODE(0), .PERF_WIDTH(PERF_W)) u_snt (
    .clk(clk), .rst(rst), .freeze(freeze), .lookupPc(lookupPc),
    .predictTaken(pt0), .predictTarget(ptgt0),
    .updateValid(updateValid), .updateIsBranch(updateIsBranch), .updatePc(updatePc),
    .updateTaken(updateTaken), .updateTarget(updateTarget),
    .updatePredictedTaken(updatePredictedTaken), .updatePredictedTarget(updatePredictedTarget),
    .mispredict(mp0), .correctPc(cpc0), .branchCount(bc0), .mispredictCount(mc0));

  // Reference model: table of entries with an integer confidence 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  longint      m_bc, m_mc;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return int'((pc >> (2 + IDX)) % (32'd1 << TAG_W));
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pt(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(logic [31:0] pc);
    return m_pt(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mp();
    if (!updateValid) return 1'b0;
    if (updateIsBranch)
      return (updatePredictedTaken != updateTaken) ||
             (updateTaken && updatePredictedTarget != updateTarget);
    return updatePredictedTaken;
  endfunction

  function automatic logic [31:0] m_cpc();
    return (updateIsBranch && updateTaken) ? updateTarget : updatePc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock();
    int i;
    if (!rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 1;
      end
      m_bc = 0;
      m_mc = 0;
    end else if (updateValid && !freeze) begin
      if (updateIsBranch && m_bc < CMAX) m_bc++;
      if (m_mp() && m_mc < CMAX) m_mc++;
      i = idx_of(updatePc);
      if (updateIsBranch) begin
        if (m_hit(updatePc)) begin
          m_ctr[i] = updateTaken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                 : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
          if (updateTaken) m_tgt[i] = updateTarget;
        end else if (updateTaken) begin
          m_valid[i] = 1;
          m_tag[i]   = tag_of(updatePc);
          m_tgt[i]   = updateTarget;
          m_ctr[i]   = 2;
        end
      end else if (m_hit(updatePc)) begin
        m_valid[i] = 0;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    chk("pt",     pt1,   m_pt(lookupPc));
    chk("ptgt",   ptgt1, m_ptgt(lookupPc));
    chk("mp",     mp1,   m_mp());
    chk("cpc",    cpc1,  m_cpc());
    chk("bc",     bc1,   m_bc);
    chk("mc",     mc1,   m_mc);
    chk("m0_pt",  pt0,   1'b0);
    chk("m0_ptgt", ptgt0, lookupPc + 32'd4);
    chk("m0_mp",  mp0,   m_mp());
    chk("m0_cpc", cpc0,  m_cpc());
    chk("m0_bc",  bc0,   m_bc);
    chk("m0_mc",  mc0,   m_mc);
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic upd(input bit br, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input bit ppt, input logic [31:0] ptgt);
    updateValid = 1'b1;
    updateIsBranch = br;
    updatePc = pc;
    updateTaken = tk;
    updateTarget = tgt;
    updatePredictedTaken = ppt;
    updatePredictedTarget = ptgt;
  endtask

  task automatic noupd();
    updateValid = 1'b0;
    updateIsBranch = 1'b0;
    updatePc = '0;
    updateTaken = 1'b0;
    updateTarget = '0;
    updatePredictedTaken = 1'b0;
    updatePredictedTarget = '0;
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
    if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_C000;
    return pc;
  endfunction

  initial begin
    longint bc_saved;
    logic [31:0] pc;
    rst = 1'b0;
    freeze = 1'b0;
    lookupPc = 32'h100;
    noupd();
    #1;
    at_pos();
    at_pos();
    rst = 1'b1;

    // Reset state
    at_neg();
    chk("rst_pt", pt1, 1'b0);
    chk("rst_ptgt", ptgt1, 32'h104);
    chk("rst_bc", bc1, 0);
    chk("rst_mc", mc1, 0);
    at_pos();

    // Allocate on taken miss; same-cycle lookup still misses
    upd(1, 32'h100, 1, 32'h40, 0, 32'h104);
    at_neg();
    chk("alloc_mp", mp1, 1'b1);
    chk("alloc_cpc", cpc1, 32'h40);
    chk("same_cyc_pt", pt1, 1'b0);
    chk("m0_alloc_mp", mp0, 1'b1);
    at_pos();
    noupd();
    at_neg();
    chk("alloc_pt", pt1, 1'b1);
    chk("alloc_ptgt", ptgt1, 32'h40);
    chk("m0_after_pt", pt0, 1'b0);
    chk("m0_after_bc", bc0, 1);
    at_pos();

    // Hysteresis
    upd(1, 32'h100, 0, 32'h40, 1, 32'h40);
    at_neg(); at_pos();
    noupd();
    at_neg();
    chk("hyst_nt_pt", pt1, 1'b0);
    at_pos();
    for (int k = 0; k < 3; k++) begin
      upd(1, 32'h100, 1, 32'h40, 0, 32'h104);
      at_neg(); at_pos();
    end
    upd(1, 32'h100, 0, 32'h40, 1, 32'h40);
    at_neg(); at_pos();
    noupd();
    at_neg();
    chk("hyst_st_pt", pt1, 1'b1);
    at_pos();

    // Alias with a different tag, then non-branch alias clears the entry
    lookupPc = 32'h140;
    at_neg();
    chk("alias_pt", pt1, 1'b0);
    chk("alias_ptgt", ptgt1, 32'h144);
    at_pos();
    lookupPc = 32'h100;
    upd(0, 32'h100, 0, 32'h0, 1, 32'h40);
    at_neg();
    chk("nb_mp", mp1, 1'b1);
    chk("nb_cpc", cpc1, 32'h104);
    chk("nb_same_cyc_pt", pt1, 1'b1);
    at_pos();
    noupd();
    at_neg();
    chk("nb_cleared_pt", pt1, 1'b0);
    at_pos();

    // Freeze
    upd(1, 32'h100, 1, 32'h80, 0, 32'h104);
    at_neg(); at_pos();
    bc_saved = m_bc;
    freeze = 1'b1;
    upd(1, 32'h100, 0, 32'h80, 1, 32'h80);
    at_neg(); at_pos();
    upd(1, 32'h100, 0, 32'h80, 1, 32'h80);
    at_neg(); at_pos();
    freeze = 1'b0;
    noupd();
    at_neg();
    chk("frz_pt", pt1, 1'b1);
    chk("frz_ptgt", ptgt1, 32'h80);
    chk("frz_bc", bc1, bc_saved);
    at_pos();

    // Drive both perf counters into saturation
    for (int k = 0; k < 70; k++) begin
      pc = rpc();
      lookupPc = rpc();
      upd(1, pc, 1, 32'h2000 + (pc & 32'hFC), 0, pc + 32'd4);
      at_neg(); at_pos();
    end
    noupd();
    at_neg();
    chk("sat_bc", bc1, CMAX);
    chk("sat_mc", mc1, CMAX);
    at_pos();

    // Randomised traffic, with occasional freeze and reset
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 149) != 0);
      freeze = ($urandom_range(0, 7) == 0);
      lookupPc = rpc();
      if ($urandom_range(0, 4) == 0) noupd();
      else begin
        pc = rpc();
        upd($urandom_range(0, 5) != 0, pc, $urandom_range(0, 1),
            32'h3000 + ($urandom_range(0, 3) << 4), 0, 0);
        if ($urandom_range(0, 1) == 1) begin
          updatePredictedTaken = m_pt(pc);
          updatePredictedTarget = m_ptgt(pc);
        end else begin
          updatePredictedTaken = $urandom_range(0, 1);
          updatePredictedTarget = 32'h3000 + ($urandom_range(0, 3) << 4);
        end
      end
      at_neg(); at_pos();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
